// File: rtl/onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter
//   Two-master Avalon-MM arbiter in front of a single-port on-chip RAM with
//   1-cycle read latency. Round-robin between the masters, an optional
//   per-master lock for atomic read-modify-write sequences, a lock-timeout
//   counter that frees an abandoned lock, and fixed-latency readdatavalid
//   routed back to the master that issued the read.
//
//   Ports
//     clk, reset                  system clock, synchronous active-high reset
//     mN_address/byteenable/read/write/writedata/lock   master N request
//     mN_waitrequest              master N stall (req & ~grant)
//     mN_readdata/readdatavalid   master N read return (shared data bus)
//     mem_*                       RAM port; clken tied high, fields zero
//                                 when nothing is granted
//
//   Lock owner state
//     state    | meaning
//     OWN_NONE | no lock held; round-robin between requesters
//     OWN_M0   | master 0 holds the RAM; master 1 waits
//     OWN_M1   | master 1 holds the RAM; master 0 waits
// ---------------------------------------------------------------------------
module onchip_mem_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic                m0_lock,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic                m1_lock,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_TC =
        CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    owner_e           owner_q,      owner_d;
    logic [CNT_W-1:0] lock_cnt_q,   lock_cnt_d;
    logic             rd_pending_q, rd_pending_d;
    logic             rd_id_q,      rd_id_d;
    logic             last_grant_q, last_grant_d;

    logic req0, req1;
    logic gnt0, gnt1, gnt_any;
    logic sel_write, sel_read, sel_lock;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grant is combinational; a lock owner excludes the other master.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (owner_q)
            OWN_M0:  gnt0 = req0;
            OWN_M1:  gnt1 = req1;
            default: begin
                if (req0 && req1) begin
                    gnt0 = last_grant_q;
                    gnt1 = ~last_grant_q;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

    assign gnt_any = gnt0 | gnt1;

    assign m0_waitrequest = req0 & ~gnt0;
    assign m1_waitrequest = req1 & ~gnt1;

    // Write wins when a master asserts read and write together.
    assign sel_write = gnt1 ? m1_write : (gnt0 & m0_write);
    assign sel_read  = gnt1 ? (m1_read & ~m1_write) : (gnt0 & m0_read & ~m0_write);
    assign sel_lock  = gnt1 ? m1_lock : (gnt0 & m0_lock);

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        if (gnt0) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
        end else if (gnt1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
        end
    end

    assign mem_chipselect = gnt_any;
    assign mem_write      = sel_write;
    assign mem_clken      = 1'b1;

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_pending_q & ~rd_id_q;
    assign m1_readdatavalid = rd_pending_q &  rd_id_q;

    always_comb begin
        owner_d      = owner_q;
        lock_cnt_d   = lock_cnt_q;
        last_grant_d = gnt_any ? gnt1 : last_grant_q;
        rd_pending_d = sel_read;
        rd_id_d      = gnt_any ? gnt1 : rd_id_q;

        if (gnt_any) begin
            // Any grant while locked belongs to the owner, so a grant with
            // lock=0 is either a no-lock transfer or the owner's release.
            owner_d    = sel_lock ? (gnt1 ? OWN_M1 : OWN_M0) : OWN_NONE;
            lock_cnt_d = '0;
        end else if (owner_q != OWN_NONE && LOCK_TIMEOUT != 0) begin
            // The owner is always granted when it requests, so no grant
            // here means the owner is idle this cycle.
            if (lock_cnt_q == CNT_TC) begin
                owner_d    = OWN_NONE;
                lock_cnt_d = '0;
            end else begin
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= OWN_NONE;
            lock_cnt_q   <= '0;
            rd_pending_q <= 1'b0;
            rd_id_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            owner_q      <= owner_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_pending_q <= rd_pending_d;
            rd_id_q      <= rd_id_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
module tb_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic [12:0] m0_address,  m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m0_lock;
    logic        m1_read, m1_write, m1_lock;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;

    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.ADDR_W(13), .DATA_W(32), .LOCK_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_lock(m0_lock), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_lock(m1_lock), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // RAM behind the arbiter: byte-enabled writes, 1-cycle read latency.
    logic [31:0] ram [0:8191];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b])
                        ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_address = '0; m0_byteenable = '0; m0_read = 0; m0_write = 0;
        m0_writedata = '0; m0_lock = 0;
        m1_address = '0; m1_byteenable = '0; m1_read = 0; m1_write = 0;
        m1_writedata = '0; m1_lock = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_all();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_all();
        step();
        step();
        @(negedge clk);
        n_cmp++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
            n_err++; $display("FAIL reset_rdv: got %b%b exp 00", m0_readdatavalid, m1_readdatavalid); end
        n_cmp++; if (mem_chipselect !== 1'b0 || mem_address !== 13'd0) begin
            n_err++; $display("FAIL reset_idle_mem: cs=%b addr=%h exp cs=0 addr=0", mem_chipselect, mem_address); end
        n_cmp++; if (mem_clken !== 1'b1) begin
            n_err++; $display("FAIL reset_clken: got %b exp 1", mem_clken); end
        n_cmp++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b0) begin
            n_err++; $display("FAIL reset_wait_noreq: got %b%b exp 00", m0_waitrequest, m1_waitrequest); end
        step();
        reset = 1'b0;
    endtask

    task automatic test_solo_read();
        m0_write = 1; m0_address = 13'h0005; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
        @(negedge clk);
        n_cmp++; if (m0_waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_writedata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL solo_write: wait=%b wr=%b data=%h exp 0 1 deadbeef", m0_waitrequest, mem_write, mem_writedata); end
        step();
        m0_write = 0; m0_read = 1;
        @(negedge clk);
        n_cmp++; if (m0_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_write !== 1'b0 || mem_address !== 13'h0005) begin
            n_err++; $display("FAIL solo_read_issue: wait=%b cs=%b wr=%b addr=%h exp 0 1 0 0005", m0_waitrequest, mem_chipselect, mem_write, mem_address); end
        step();
        idle_all();
        @(negedge clk);
        n_cmp++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF || m1_readdatavalid !== 1'b0) begin
            n_err++; $display("FAIL solo_read_data: rdv0=%b data=%h rdv1=%b exp 1 deadbeef 0", m0_readdatavalid, m0_readdata, m1_readdatavalid); end
        step();
        @(negedge clk);
        n_cmp++; if (m0_readdatavalid !== 1'b0) begin
            n_err++; $display("FAIL solo_read_single: rdv0=%b exp 0", m0_readdatavalid); end
        step();
    endtask

    task automatic test_contention();
        logic exp_w0, exp_w1;
        do_reset();
        m0_write = 1; m0_address = 13'h0010; m0_writedata = 32'hA0A0A0A0; m0_byteenable = 4'hF;
        m1_write = 1; m1_address = 13'h0020; m1_writedata = 32'hB0B0B0B0; m1_byteenable = 4'hF;
        for (int i = 0; i < 4; i++) begin
            exp_w0 = (i % 2) != 0;
            exp_w1 = (i % 2) == 0;
            @(negedge clk);
            n_cmp++; if (m0_waitrequest !== exp_w0 || m1_waitrequest !== exp_w1) begin
                n_err++; $display("FAIL contention_wait[%0d]: got %b%b exp %b%b", i, m0_waitrequest, m1_waitrequest, exp_w0, exp_w1); end
            n_cmp++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b1 ||
                         mem_writedata !== (exp_w0 ? 32'hB0B0B0B0 : 32'hA0A0A0A0) ||
                         mem_address !== (exp_w0 ? 13'h0020 : 13'h0010)) begin
                n_err++; $display("FAIL contention_mux[%0d]: cs=%b wr=%b addr=%h data=%h", i, mem_chipselect, mem_write, mem_address, mem_writedata); end
            step();
        end
        idle_all();
    endtask

    task automatic test_byte_write();
        m1_write = 1; m1_address = 13'h0030; m1_writedata = 32'h11223344; m1_byteenable = 4'hF;
        step();
        m1_writedata = 32'h000000AA; m1_byteenable = 4'b0001;
        @(negedge clk);
        n_cmp++; if (m1_waitrequest !== 1'b0 || mem_byteenable !== 4'b0001) begin
            n_err++; $display("FAIL byte_write_be: wait=%b be=%b exp 0 0001", m1_waitrequest, mem_byteenable); end
        step();
        m1_write = 0; m1_read = 1; m1_byteenable = 4'hF;
        step();
        idle_all();
        @(negedge clk);
        n_cmp++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h112233AA || m0_readdatavalid !== 1'b0) begin
            n_err++; $display("FAIL byte_write_readback: rdv1=%b data=%h rdv0=%b exp 1 112233aa 0", m1_readdatavalid, m1_readdata, m0_readdatavalid); end
        step();
    endtask

    task automatic test_back_to_back();
        m0_read = 1; m0_address = 13'h0010;
        step();
        m0_read = 0; m1_read = 1; m1_address = 13'h0020;
        @(negedge clk);
        n_cmp++; if (m1_waitrequest !== 1'b0 || m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hA0A0A0A0 || m1_readdatavalid !== 1'b0) begin
            n_err++; $display("FAIL b2b_first: wait1=%b rdv0=%b data=%h rdv1=%b exp 0 1 a0a0a0a0 0", m1_waitrequest, m0_readdatavalid, m0_readdata, m1_readdatavalid); end
        step();
        idle_all();
        @(negedge clk);
        n_cmp++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hB0B0B0B0 || m0_readdatavalid !== 1'b0) begin
            n_err++; $display("FAIL b2b_second: rdv1=%b data=%h rdv0=%b exp 1 b0b0b0b0 0", m1_readdatavalid, m1_readdata, m0_readdatavalid); end
        step();
    endtask

    task automatic test_write_wins();
        m0_read = 1; m0_write = 1; m0_address = 13'h0050; m0_writedata = 32'h12345678; m0_byteenable = 4'hF;
        @(negedge clk);
        n_cmp++; if (mem_write !== 1'b1) begin
            n_err++; $display("FAIL write_wins_wr: got %b exp 1", mem_write); end
        step();
        idle_all();
        @(negedge clk);
        n_cmp++; if (m0_readdatavalid !== 1'b0) begin
            n_err++; $display("FAIL write_wins_no_rdv: got %b exp 0", m0_readdatavalid); end
        step();
    endtask

    task automatic test_lock_rmw();
        do_reset();
        m0_read = 1; m0_lock = 1; m0_address = 13'h0005;
        m1_write = 1; m1_address = 13'h0040; m1_writedata = 32'h55; m1_byteenable = 4'hF;
        @(negedge clk);
        n_cmp++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
            n_err++; $display("FAIL lock_c0_wait: got %b%b exp 01", m0_waitrequest, m1_waitrequest); end
        step();
        m0_read = 0; m0_lock = 0;
        @(negedge clk);
        n_cmp++; if (m1_waitrequest !== 1'b1 || mem_chipselect !== 1'b0) begin
            n_err++; $display("FAIL lock_c1_hold: wait1=%b cs=%b exp 1 0", m1_waitrequest, mem_chipselect); end
        n_cmp++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL lock_c1_rdata: rdv0=%b data=%h exp 1 deadbeef", m0_readdatavalid, m0_readdata); end
        step();
        m0_write = 1; m0_writedata = 32'hDEADBEF0; m0_byteenable = 4'hF;
        @(negedge clk);
        n_cmp++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
            n_err++; $display("FAIL lock_c2_unlock: got %b%b exp 01", m0_waitrequest, m1_waitrequest); end
        step();
        m0_write = 0;
        @(negedge clk);
        n_cmp++; if (m1_waitrequest !== 1'b0 || mem_address !== 13'h0040) begin
            n_err++; $display("FAIL lock_c3_m1_grant: wait1=%b addr=%h exp 0 0040", m1_waitrequest, mem_address); end
        step();
        idle_all();
    endtask

    task automatic test_lock_timeout();
        m0_write = 1; m0_lock = 1; m0_address = 13'h0060; m0_writedata = 32'h1; m0_byteenable = 4'hF;
        m1_read = 1; m1_address = 13'h0030;
        @(negedge clk);
        n_cmp++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
            n_err++; $display("FAIL timeout_lock_grant: got %b%b exp 01", m0_waitrequest, m1_waitrequest); end
        step();
        m0_write = 0; m0_lock = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_cmp++; if (m1_waitrequest !== 1'b1 || m0_waitrequest !== 1'b0) begin
                n_err++; $display("FAIL timeout_held[%0d]: wait1=%b wait0=%b exp 1 0", i, m1_waitrequest, m0_waitrequest); end
            step();
        end
        @(negedge clk);
        n_cmp++; if (m1_waitrequest !== 1'b0) begin
            n_err++; $display("FAIL timeout_release: wait1=%b exp 0", m1_waitrequest); end
        step();
        idle_all();
        @(negedge clk);
        n_cmp++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h112233AA) begin
            n_err++; $display("FAIL timeout_read: rdv1=%b data=%h exp 1 112233aa", m1_readdatavalid, m1_readdata); end
        step();
    endtask

    task automatic test_reset_mid_lock();
        m0_write = 1; m0_lock = 1; m0_address = 13'h0060; m0_writedata = 32'h2; m0_byteenable = 4'hF;
        step();
        idle_all();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m1_write = 1; m1_address = 13'h0061; m1_writedata = 32'h3; m1_byteenable = 4'hF;
        @(negedge clk);
        n_cmp++; if (m1_waitrequest !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_lock: wait1=%b exp 0", m1_waitrequest); end
        step();
        idle_all();
    endtask

    task automatic test_reset_mid_read();
        reset = 1'b1;
        m1_read = 1; m1_address = 13'h0030;
        @(negedge clk);
        n_cmp++; if (m1_waitrequest !== 1'b0 || mem_chipselect !== 1'b1) begin
            n_err++; $display("FAIL reset_read_grant: wait1=%b cs=%b exp 0 1", m1_waitrequest, mem_chipselect); end
        step();
        reset = 1'b0;
        idle_all();
        @(negedge clk);
        n_cmp++; if (m1_readdatavalid !== 1'b0 || m0_readdatavalid !== 1'b0) begin
            n_err++; $display("FAIL reset_read_no_rdv: got %b%b exp 00", m0_readdatavalid, m1_readdatavalid); end
        step();
        m0_write = 1; m0_address = 13'h0070; m0_writedata = 32'h7; m0_byteenable = 4'hF;
        m1_write = 1; m1_address = 13'h0071; m1_writedata = 32'h8; m1_byteenable = 4'hF;
        @(negedge clk);
        n_cmp++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
            n_err++; $display("FAIL reset_tie_m0: got %b%b exp 01", m0_waitrequest, m1_waitrequest); end
        step();
        idle_all();
    endtask

    initial begin
        reset = 1'b1;
        idle_all();
        test_reset();
        test_solo_read();
        test_contention();
        test_byte_write();
        test_back_to_back();
        test_write_wins();
        test_lock_rmw();
        test_lock_timeout();
        test_reset_mid_lock();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
